// File: rtl/matrix_loader_pkg.sv
// ============================================================================
// Module  : matrix_loader_pkg
// Brief   : Shared defaults, fill-order encoding and position helper for the
//           double-buffered matrix loader.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package matrix_loader_pkg;

  localparam int DEF_W    = 8;
  localparam int DEF_ROWS = 3;
  localparam int DEF_COLS = 3;

  typedef enum logic {
    FILL_ROW_MAJOR = 1'b0,
    FILL_COL_MAJOR = 1'b1
  } fill_order_e;

  // Flat position of element (row, col) inside the packed matrix.
  function automatic int pos(input int row, input int col, input int cols);
    return row * cols + col;
  endfunction

endpackage

`default_nettype wire

// File: rtl/matrix_loader_if.sv
// ============================================================================
// Module  : matrix_loader_if
// Brief   : Element stream in, matrix out handshake bundle for matrix_loader.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface matrix_loader_if #(
  parameter int W = 8,
  parameter int N = 9
);

  logic [W-1:0]   i_data;
  logic           i_valid;
  logic           i_sof;
  logic           o_ready;
  logic [N*W-1:0] o_mat;
  logic           o_mat_valid;
  logic           i_mat_ready;
  logic           o_resync;

  modport master (
    output i_data, i_valid, i_sof, i_mat_ready,
    input  o_ready, o_mat, o_mat_valid, o_resync
  );

  modport slave (
    input  i_data, i_valid, i_sof, i_mat_ready,
    output o_ready, o_mat, o_mat_valid, o_resync
  );

endinterface

`default_nettype wire

// File: rtl/matrix_loader_bank.sv
// ============================================================================
// Module  : matrix_loader_bank
// Brief   : One N-element register bank with a single positional write port
//           and a flat read port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module matrix_loader_bank #(
  parameter int W  = 8,
  parameter int N  = 9,
  parameter int PW = 4
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_we,
  input  logic [PW-1:0]  i_pos,
  input  logic [W-1:0]   i_data,
  output logic [N*W-1:0] o_mat
);

  for (genvar p = 0; p < N; p++) begin : g_elem
    logic [W-1:0] r_elem;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_elem <= '0;
      end else if (i_we && (i_pos == PW'(p))) begin
        r_elem <= i_data;
      end
    end

    assign o_mat[p*W +: W] = r_elem;
  end

endmodule

`default_nettype wire

// File: rtl/matrix_loader.sv
// ============================================================================
// Module  : matrix_loader
// Brief   : Ping-pong loader packing a W-bit element stream into ROWS x COLS
//           matrices, with start-of-frame resync and row/column fill order.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module matrix_loader
  import matrix_loader_pkg::*;
#(
  parameter int W         = DEF_W,
  parameter int ROWS      = DEF_ROWS,
  parameter int COLS      = DEF_COLS,
  parameter bit COL_MAJOR = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  matrix_loader_if.slave   bus
);

  localparam int N  = ROWS * COLS;
  localparam int KW = $clog2(N) + 1;
  localparam int RW = $clog2(ROWS) + 1;
  localparam int CW = $clog2(COLS) + 1;
  localparam int PW = $clog2(N) + 1;

  localparam fill_order_e c_order = COL_MAJOR ? FILL_COL_MAJOR : FILL_ROW_MAJOR;

  logic          r_live;
  logic          r_wr_bank;
  logic          r_rd_bank;
  logic [1:0]    r_full;
  logic [KW-1:0] r_k;
  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic          r_resync;

  logic          w_ready;
  logic          w_accept;
  logic          w_mat_valid;
  logic          w_release;
  logic [KW-1:0] w_k;
  logic [RW-1:0] w_row;
  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row_nxt;
  logic [CW-1:0] w_col_nxt;
  logic          w_last;
  logic [PW-1:0] w_pos;
  logic [N*W-1:0] w_bank_mat [2];

  // r_live keeps o_ready low until the first edge after reset release.
  assign w_ready     = r_live & ~r_full[r_wr_bank];
  assign w_accept    = bus.i_valid & w_ready;
  assign w_mat_valid = r_full[r_rd_bank];
  assign w_release   = w_mat_valid & bus.i_mat_ready;

  // A start-of-frame beat restarts the fill at element 0 regardless of k.
  always_comb begin
    w_k       = bus.i_sof ? '0 : r_k;
    w_row     = bus.i_sof ? '0 : r_row;
    w_col     = bus.i_sof ? '0 : r_col;
    w_row_nxt = w_row;
    w_col_nxt = w_col;
    w_last    = (w_k == KW'(N - 1));
    w_pos     = PW'(pos(int'(w_row), int'(w_col), COLS));
    if (c_order == FILL_COL_MAJOR) begin
      if (w_row == RW'(ROWS - 1)) begin
        w_row_nxt = '0;
        w_col_nxt = w_col + CW'(1);
      end else begin
        w_row_nxt = w_row + RW'(1);
      end
    end else begin
      if (w_col == CW'(COLS - 1)) begin
        w_col_nxt = '0;
        w_row_nxt = w_row + RW'(1);
      end else begin
        w_col_nxt = w_col + CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_live    <= 1'b0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_full    <= '0;
      r_k       <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_resync  <= 1'b0;
    end else begin
      r_live   <= 1'b1;
      r_resync <= w_accept & bus.i_sof & (r_k != '0);
      if (w_accept) begin
        if (w_last) begin
          r_full[r_wr_bank] <= 1'b1;
          r_wr_bank         <= ~r_wr_bank;
          r_k               <= '0;
          r_row             <= '0;
          r_col             <= '0;
        end else begin
          r_k   <= w_k + KW'(1);
          r_row <= w_row_nxt;
          r_col <= w_col_nxt;
        end
      end
      // A completing bank and a released bank can never be the same one.
      if (w_release) begin
        r_full[r_rd_bank] <= 1'b0;
        r_rd_bank         <= ~r_rd_bank;
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    matrix_loader_bank #(
      .W  (W),
      .N  (N),
      .PW (PW)
    ) u_bank (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_we    (w_accept && (r_wr_bank == 1'(b))),
      .i_pos   (w_pos),
      .i_data  (bus.i_data),
      .o_mat   (w_bank_mat[b])
    );
  end

  assign bus.o_ready     = w_ready;
  assign bus.o_mat       = w_bank_mat[r_rd_bank];
  assign bus.o_mat_valid = w_mat_valid;
  assign bus.o_resync    = r_resync;

endmodule

`default_nettype wire

// File: tb/tb_matrix_loader.sv
// ============================================================================
// Module  : tb_matrix_loader
// Brief   : Directed bench for matrix_loader, row-major and column-major units
//           sharing one stimulus stream.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_matrix_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] d = '0;
  logic       v = 1'b0;
  logic       s = 1'b0;
  logic       mr = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  matrix_loader_if #(.W(8), .N(9)) bus    ();
  matrix_loader_if #(.W(8), .N(9)) bus_cm ();

  assign bus.i_data       = d;
  assign bus.i_valid      = v;
  assign bus.i_sof        = s;
  assign bus.i_mat_ready  = mr;
  assign bus_cm.i_data      = d;
  assign bus_cm.i_valid     = v;
  assign bus_cm.i_sof       = s;
  assign bus_cm.i_mat_ready = mr;

  matrix_loader #(.W(8), .ROWS(3), .COLS(3), .COL_MAJOR(1'b0)) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  matrix_loader #(.W(8), .ROWS(3), .COLS(3), .COL_MAJOR(1'b1)) u_dut_cm (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_cm)
  );

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs settle 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] val, input logic sof);
    d = val;
    s = sof;
    v = 1'b1;
    cyc();
    v = 1'b0;
    s = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) cyc();
    check("rst_ready",   72'(bus.o_ready),     72'd0);
    check("rst_valid",   72'(bus.o_mat_valid), 72'd0);
    check("rst_mat",     bus.o_mat,            72'd0);
    check("rst_resync",  72'(bus.o_resync),    72'd0);
    rst_n = 1'b1;
    cyc();
    check("ready_after_rst", 72'(bus.o_ready), 72'd1);

    // Fill bank 0 with 1..9
    for (int i = 1; i <= 9; i++) begin
      beat(8'(i), 1'b0);
      if (i == 8) check("valid_before_last", 72'(bus.o_mat_valid), 72'd0);
    end
    check("t1_valid",   72'(bus.o_mat_valid), 72'd1);
    check("t1_mat",     bus.o_mat,            72'h09_08_07_06_05_04_03_02_01);
    check("t1_ready",   72'(bus.o_ready),     72'd1);
    check("cm_valid",   72'(bus_cm.o_mat_valid), 72'd1);
    check("cm_mat",     bus_cm.o_mat,         72'h09_06_03_08_05_02_07_04_01);

    // Fill bank 1 with 10..18 -> both full
    for (int i = 10; i <= 18; i++) beat(8'(i), 1'b0);
    check("both_full_ready", 72'(bus.o_ready),     72'd0);
    check("both_full_mat",   bus.o_mat,            72'h09_08_07_06_05_04_03_02_01);

    // Hold 19 while stalled, then release bank 0
    d = 8'd19;
    v = 1'b1;
    cyc();
    cyc();
    check("stall_ready", 72'(bus.o_ready), 72'd0);
    check("stall_mat",   bus.o_mat,        72'h09_08_07_06_05_04_03_02_01);
    mr = 1'b1;
    cyc();
    mr = 1'b0;
    check("rel0_valid", 72'(bus.o_mat_valid), 72'd1);
    check("rel0_mat",   bus.o_mat,            72'h12_11_10_0F_0E_0D_0C_0B_0A);
    check("rel0_ready", 72'(bus.o_ready),     72'd1);
    cyc();
    v = 1'b0;
    mr = 1'b1;
    cyc();
    mr = 1'b0;
    check("rel1_valid", 72'(bus.o_mat_valid), 72'd0);
    for (int i = 20; i <= 27; i++) beat(8'(i), 1'b0);
    check("k0_19_valid", 72'(bus.o_mat_valid), 72'd1);
    check("k0_19_mat",   bus.o_mat,            72'h1B_1A_19_18_17_16_15_14_13);
    mr = 1'b1;
    cyc();
    mr = 1'b0;

    // Start-of-frame resync
    beat(8'd1, 1'b1);
    check("sof_k0_resync", 72'(bus.o_resync), 72'd0);
    for (int i = 2; i <= 4; i++) beat(8'(i), 1'b0);
    beat(8'hAA, 1'b1);
    check("resync_pulse", 72'(bus.o_resync), 72'd1);
    for (int i = 1; i <= 8; i++) begin
      beat(8'(8'hB0 + i), 1'b0);
      if (i == 1) check("resync_clear", 72'(bus.o_resync), 72'd0);
    end
    check("resync_valid", 72'(bus.o_mat_valid), 72'd1);
    check("resync_mat",   bus.o_mat,            72'hB8_B7_B6_B5_B4_B3_B2_B1_AA);
    mr = 1'b1;
    cyc();
    mr = 1'b0;

    // Completion of bank 1 coincides with release of bank 0
    for (int i = 1; i <= 9; i++) beat(8'(i), 1'b0);
    for (int i = 1; i <= 8; i++) beat(8'(8'h20 + i), 1'b0);
    mr = 1'b1;
    beat(8'h29, 1'b0);
    mr = 1'b0;
    check("same_cyc_valid", 72'(bus.o_mat_valid), 72'd1);
    check("same_cyc_mat",   bus.o_mat,            72'h29_28_27_26_25_24_23_22_21);
    check("same_cyc_ready", 72'(bus.o_ready),     72'd1);
    mr = 1'b1;
    cyc();
    mr = 1'b0;

    // Asynchronous reset part-way through a fill
    for (int i = 1; i <= 5; i++) beat(8'(8'h50 + i), 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_ready", 72'(bus.o_ready),     72'd0);
    check("async_rst_valid", 72'(bus.o_mat_valid), 72'd0);
    check("async_rst_mat",   bus.o_mat,            72'd0);
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    for (int i = 1; i <= 9; i++) beat(8'(i), 1'b0);
    check("post_rst_valid", 72'(bus.o_mat_valid), 72'd1);
    check("post_rst_mat",   bus.o_mat,            72'h09_08_07_06_05_04_03_02_01);
    check("post_rst_cm",    bus_cm.o_mat,         72'h09_06_03_08_05_02_07_04_01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
